// File: rtl/fxp_perceptron_trainer.sv
// Sequential perceptron-rule trainer producing sign-magnitude Q3.12 weights for the inference neuron.
// Optional macro FXP_TRAIN_SAT_EN: saturate weight updates to +/-32767 instead of wrapping.
module fxp_perceptron_trainer #(
  parameter int TAM        = 16,
  parameter int MAX_EPOCHS = 16,
  parameter int ETA_SHIFT  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [4*TAM-1:0]   in1,
  input  logic [4*TAM-1:0]   in2,
  input  logic [4*TAM-1:0]   d,
  input  logic [TAM-1:0]     w0_init,
  input  logic [TAM-1:0]     w1_init,
  input  logic [TAM-1:0]     w2_init,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [7:0]         epochs,
  output logic [TAM-1:0]     w0,
  output logic [TAM-1:0]     w1,
  output logic [TAM-1:0]     w2
);

  localparam int ACC_W = 2*TAM + 2;
  localparam logic signed [TAM-1:0]   X0       = TAM'(1 << (TAM-4));
  localparam logic [TAM-1:0]          MAG_MASK = {1'b0, {(TAM-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE, CHECK} state_t;

  state_t state, state_nxt;

  logic signed [TAM-1:0]   w0_q, w1_q, w2_q;
  logic signed [TAM-1:0]   x1_q [4];
  logic signed [TAM-1:0]   x2_q [4];
  logic [3:0]              t_q;
  logic [1:0]              idx;
  logic                    err_flag;
  logic signed [ACC_W-1:0] acc_p1;

  logic signed [2*TAM-1:0] p0, p1, p2;
  logic signed [ACC_W-1:0] acc_c;
  logic signed [TAM-1:0]   dx0, dx1, dx2;
  logic                    y, t, miss;
  logic [7:0]              epochs_inc;
  logic                    stop;

  function automatic logic signed [TAM-1:0] sm_to_tc(input logic [TAM-1:0] sm);
    logic signed [TAM-1:0] mag;
    mag = {1'b0, sm[TAM-2:0]};
    return sm[TAM-1] ? -mag : mag;
  endfunction

  // -32768 has no sign-magnitude twin; its negation keeps bit TAM-1 set, giving 0x8000.
  function automatic logic [TAM-1:0] tc_to_sm(input logic signed [TAM-1:0] v);
    logic signed [TAM-1:0] mag;
    mag = -v;
    return v[TAM-1] ? {1'b1, mag[TAM-2:0]} : v;
  endfunction

  function automatic logic signed [TAM-1:0] upd(input logic signed [TAM-1:0] w,
                                                input logic signed [TAM-1:0] dx,
                                                input logic               neg);
    logic signed [TAM:0] s;
`ifdef FXP_TRAIN_SAT_EN
    logic signed [TAM-1:0] lim;
    lim = {1'b0, {(TAM-1){1'b1}}};
`endif
    s = neg ? ((TAM+1)'(w) - (TAM+1)'(dx)) : ((TAM+1)'(w) + (TAM+1)'(dx));
`ifdef FXP_TRAIN_SAT_EN
    if (s > (TAM+1)'(lim)) return lim;
    if (s < -(TAM+1)'(lim)) return -lim;
`endif
    return s[TAM-1:0];
  endfunction

  // EVAL stage: full-precision dot product of the current sample
  always_comb begin
    p0    = (2*TAM)'(w0_q) * (2*TAM)'(X0);
    p1    = (2*TAM)'(w1_q) * (2*TAM)'(x1_q[idx]);
    p2    = (2*TAM)'(w2_q) * (2*TAM)'(x2_q[idx]);
    acc_c = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2);
  end

  // UPDATE stage: classify registered sum and derive the scaled input steps
  always_comb begin
    y          = (acc_p1 >= ACC_ZERO);
    t          = t_q[idx];
    miss       = (y != t);
    dx0        = X0 >>> ETA_SHIFT;
    dx1        = x1_q[idx] >>> ETA_SHIFT;
    dx2        = x2_q[idx] >>> ETA_SHIFT;
    epochs_inc = epochs + 8'd1;
    stop       = !err_flag || (epochs_inc == 8'(MAX_EPOCHS));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EVAL;
      EVAL:    state_nxt = UPDATE;
      UPDATE:  state_nxt = (idx == 2'd3) ? CHECK : EVAL;
      CHECK:   state_nxt = stop ? IDLE : EVAL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      epochs    <= 8'd0;
      idx       <= 2'd0;
      err_flag  <= 1'b0;
      w0_q      <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy      <= 1'b1;
          converged <= 1'b0;
          epochs    <= 8'd0;
          idx       <= 2'd0;
          err_flag  <= 1'b0;
          w0_q      <= sm_to_tc(w0_init);
          w1_q      <= sm_to_tc(w1_init);
          w2_q      <= sm_to_tc(w2_init);
        end
        UPDATE: begin
          if (miss) begin
            // err = t - y: add the step when the target is 1, subtract otherwise
            w0_q     <= upd(w0_q, dx0, !t);
            w1_q     <= upd(w1_q, dx1, !t);
            w2_q     <= upd(w2_q, dx2, !t);
            err_flag <= 1'b1;
          end
          idx <= idx + 2'd1;
        end
        CHECK: begin
          epochs <= epochs_inc;
          idx    <= 2'd0;
          if (stop) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            converged <= !err_flag;
          end else begin
            err_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Data capture and sum register carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int i = 0; i < 4; i++) begin
        x1_q[i] <= sm_to_tc(in1[i*TAM +: TAM]);
        x2_q[i] <= sm_to_tc(in2[i*TAM +: TAM]);
        t_q[i]  <= ((d[i*TAM +: TAM] & MAG_MASK) != '0);
      end
    end
    if (state == EVAL) acc_p1 <= acc_c;
  end

  assign w0 = tc_to_sm(w0_q);
  assign w1 = tc_to_sm(w1_q);
  assign w2 = tc_to_sm(w2_q);

endmodule

// File: tb/tb_fxp_perceptron_trainer.sv
// Directed and randomized bench for fxp_perceptron_trainer against an integer reference model.
module tb_fxp_perceptron_trainer;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic [63:0] in1_a, in2_a, d_a, in1_b, in2_b, d_b;
  logic [15:0] w0i_a, w1i_a, w2i_a, w0i_b, w1i_b, w2i_b;
  logic busy_a, done_a, conv_a, busy_b, done_b, conv_b;
  logic [7:0] ep_a, ep_b;
  logic [15:0] w0_a, w1_a, w2_a, w0_b, w1_b, w2_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sx1 [4];
  logic [15:0] sx2 [4];
  logic [15:0] sd  [4];
  logic [15:0] swi [3];
  int          m_E;
  bit          m_conv;
  logic [15:0] m_w [3];
  int          last_n;

  always #5 clk = ~clk;

  fxp_perceptron_trainer #(.TAM(16), .MAX_EPOCHS(16), .ETA_SHIFT(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .in1(in1_a), .in2(in2_a), .d(d_a),
    .w0_init(w0i_a), .w1_init(w1i_a), .w2_init(w2i_a), .busy(busy_a), .done(done_a),
    .converged(conv_a), .epochs(ep_a), .w0(w0_a), .w1(w1_a), .w2(w2_a));

  fxp_perceptron_trainer #(.TAM(16), .MAX_EPOCHS(4), .ETA_SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .in1(in1_b), .in2(in2_b), .d(d_b),
    .w0_init(w0i_b), .w1_init(w1i_b), .w2_init(w2i_b), .busy(busy_b), .done(done_b),
    .converged(conv_b), .epochs(ep_b), .w0(w0_b), .w1(w1_b), .w2(w2_b));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sm2i(input logic [15:0] v);
    int m;
    m = int'(v[14:0]);
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] i2sm(input int v);
    int m;
    if (v < 0) begin
      m = -v;
      return {1'b1, m[14:0]};
    end
    return v[15:0];
  endfunction

  function automatic int wadd(input int w, input int delta);
    int r;
    logic signed [15:0] r16;
    r = w + delta;
`ifdef FXP_TRAIN_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32767) r = -32767;
`else
    r16 = 16'(r);
    r = int'(r16);
`endif
    return r;
  endfunction

  // Perceptron learning rule over the loaded truth table, plain integer arithmetic.
  task automatic model(input int eta, input int maxe);
    int w [3];
    int x [3];
    longint s;
    bit errf, y, t;
    int step;
    for (int k = 0; k < 3; k++) w[k] = sm2i(swi[k]);
    m_conv = 0;
    m_E = 0;
    for (int ep = 1; ep <= 255; ep++) begin
      errf = 0;
      for (int i = 0; i < 4; i++) begin
        x[0] = 4096;
        x[1] = sm2i(sx1[i]);
        x[2] = sm2i(sx2[i]);
        s = 0;
        for (int k = 0; k < 3; k++) s += longint'(w[k]) * longint'(x[k]);
        y = (s >= 0);
        t = ((sd[i] & 16'h7FFF) != 16'h0);
        if (y != t) begin
          errf = 1;
          for (int k = 0; k < 3; k++) begin
            step = x[k] >>> eta;
            w[k] = wadd(w[k], t ? step : -step);
          end
        end
      end
      m_E = ep;
      if (!errf) begin
        m_conv = 1;
        break;
      end
      if (ep == maxe) break;
    end
    for (int k = 0; k < 3; k++) m_w[k] = i2sm(w[k]);
  endtask

  task automatic load(input bit sel);
    logic [63:0] v1, v2, vd;
    for (int i = 0; i < 4; i++) begin
      v1[i*16 +: 16] = sx1[i];
      v2[i*16 +: 16] = sx2[i];
      vd[i*16 +: 16] = sd[i];
    end
    if (sel) begin
      in1_b = v1; in2_b = v2; d_b = vd;
      w0i_b = swi[0]; w1i_b = swi[1]; w2i_b = swi[2];
    end else begin
      in1_a = v1; in2_a = v2; d_a = vd;
      w0i_a = swi[0]; w1i_a = swi[1]; w2i_a = swi[2];
    end
  endtask

  task automatic set_tt(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3,
                        c0, c1, c2, c3, i0, i1, i2);
    sx1[0] = a0; sx1[1] = a1; sx1[2] = a2; sx1[3] = a3;
    sx2[0] = b0; sx2[1] = b1; sx2[2] = b2; sx2[3] = b3;
    sd[0]  = c0; sd[1]  = c1; sd[2]  = c2; sd[3]  = c3;
    swi[0] = i0; swi[1] = i1; swi[2] = i2;
  endtask

  // mode 1: pulse start and scramble inputs mid-run; mode 2: peek w1 after first UPDATE
  task automatic run(input string tag, input bit sel, input bit launch, input int mode,
                     input logic [15:0] peek_w1);
    int n;
    model(sel ? 0 : 1, sel ? 4 : 16);
    if (launch) @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    chk({tag, ":busy_rise"}, 32'(sel ? busy_b : busy_a), 32'd1);
    n = 0;
    while (!(sel ? done_b : done_a) && n < 3000) begin
      if (mode == 1 && n == 10) begin
        start_a = 1'b1; in1_a = ~in1_a; d_a = ~d_a; w1i_a = 16'h1234;
      end
      if (mode == 1 && n == 11) begin
        start_a = 1'b0;
        load(1'b0);
      end
      @(posedge clk); #1;
      n++;
      if (mode == 2 && n == 2) chk({tag, ":w1_first_update"}, 32'(w1_b), 32'(peek_w1));
    end
    last_n = n;
    chk({tag, ":cycles"}, n, 9 * m_E);
    chk({tag, ":done"}, 32'(sel ? done_b : done_a), 32'd1);
    chk({tag, ":busy_fall"}, 32'(sel ? busy_b : busy_a), 32'd0);
    chk({tag, ":converged"}, 32'(sel ? conv_b : conv_a), 32'(m_conv));
    chk({tag, ":epochs"}, 32'(sel ? ep_b : ep_a), m_E);
    chk({tag, ":w0"}, 32'(sel ? w0_b : w0_a), 32'(m_w[0]));
    chk({tag, ":w1"}, 32'(sel ? w1_b : w1_a), 32'(m_w[1]));
    chk({tag, ":w2"}, 32'(sel ? w2_b : w2_a), 32'(m_w[2]));
  endtask

  function automatic logic [15:0] rnd_x();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'h1000;
      2:       return 16'h9000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] rnd_d();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'h8000;
      default: return {1'($urandom), 15'($urandom) | 15'h1};
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    set_tt(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    load(1'b0);
    load(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset:busy", 32'(busy_a), 0);
    chk("reset:done", 32'(done_a), 0);
    chk("reset:converged", 32'(conv_a), 0);
    chk("reset:epochs", 32'(ep_a), 0);
    chk("reset:w0", 32'(w0_a), 0);
    chk("reset:w1", 32'(w1_a), 0);
    chk("reset:w2", 32'(w2_a), 0);
    chk("reset:b_w1", 32'(w1_b), 0);
    rst = 1'b0;

    // Pre-trained OR
    set_tt(16'h0000, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'h1000, 16'h1000,
           16'h0000, 16'h1000, 16'h1000, 16'h1000, 16'h8800, 16'h0800, 16'h0800);
    load(1'b0);
    run("or", 1'b0, 1'b1, 0, 16'h0);
    chk("or:spec_cycles", last_n, 9);
    chk("or:spec_conv", 32'(conv_a), 1);
    chk("or:spec_epochs", 32'(ep_a), 1);
    chk("or:spec_w0", 32'(w0_a), 32'h8800);
    chk("or:spec_w1", 32'(w1_a), 32'h0800);

    // AND from zero weights
    set_tt(16'h0000, 16'h1000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'h1000, 16'h1000,
           16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'h0000);
    load(1'b0);
    run("and", 1'b0, 1'b1, 0, 16'h0);
    chk("and:spec_cycles", last_n, 54);
    chk("and:spec_epochs", 32'(ep_a), 6);
    chk("and:spec_w0", 32'(w0_a), 32'h9800);
    chk("and:spec_w1", 32'(w1_a), 32'h0800);
    chk("and:spec_w2", 32'(w2_a), 32'h1000);
    repeat (3) @(posedge clk);
    #1;
    chk("and:hold_w0", 32'(w0_a), 32'h9800);
    chk("and:hold_epochs", 32'(ep_a), 6);

    // XOR never converges
    sd[1] = 16'h1000; sd[2] = 16'h1000; sd[3] = 16'h0000;
    load(1'b0);
    run("xor", 1'b0, 1'b1, 0, 16'h0);
    chk("xor:spec_cycles", last_n, 144);
    chk("xor:spec_conv", 32'(conv_a), 0);
    chk("xor:spec_epochs", 32'(ep_a), 16);

    // Mid-training reset on the AND run
    sd[1] = 16'h0000; sd[2] = 16'h0000; sd[3] = 16'h1000;
    load(1'b0);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst:busy", 32'(busy_a), 0);
    chk("midrst:done", 32'(done_a), 0);
    chk("midrst:converged", 32'(conv_a), 0);
    chk("midrst:epochs", 32'(ep_a), 0);
    chk("midrst:w0", 32'(w0_a), 0);
    chk("midrst:w1", 32'(w1_a), 0);
    chk("midrst:w2", 32'(w2_a), 0);
    rst = 1'b0;
    run("and_after_rst", 1'b0, 1'b1, 0, 16'h0);
    chk("and_after_rst:w0", 32'(w0_a), 32'h9800);

    // Start while busy with scrambled inputs, then back-to-back start in the done cycle
    run("and_poke", 1'b0, 1'b1, 1, 16'h0);
    chk("and_poke:spec_cycles", last_n, 54);
    run("and_b2b", 1'b0, 1'b0, 0, 16'h0);
    chk("and_b2b:spec_w2", 32'(w2_a), 32'h1000);

    // Update overflow on w1 with eta = 1.0
    set_tt(16'h1000, rnd_x(), rnd_x(), rnd_x(), 16'h0000, rnd_x(), rnd_x(), rnd_x(),
           16'h1000, rnd_d(), rnd_d(), rnd_d(), 16'hFFFF, 16'h7F00, 16'h0000);
    load(1'b1);
`ifdef FXP_TRAIN_SAT_EN
    run("sat", 1'b1, 1'b1, 2, 16'h7FFF);
`else
    run("wrap", 1'b1, 1'b1, 2, 16'hF100);
`endif

    // Randomized truth tables on both instances
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 4; i++) begin
        sx1[i] = rnd_x();
        sx2[i] = rnd_x();
        sd[i]  = rnd_d();
      end
      for (int k = 0; k < 3; k++) swi[k] = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0;
      load(r[0]);
      run($sformatf("rand%0d", r), r[0], 1'b1, 0, 16'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
